alu_seq: RTL and testbench

Parametrised, sequential ALU for the RISC-V core's execute stage. It decodes the same ALUOp/funct3/funct7 encodings as the combinational ALU control and executes the operation itself behind a valid/ready handshake. MUL runs on an iterative shift-add engine, so it takes several cycles. New over the current block: configurable datapath width, configurable multiply radix, ALUOp 00/01 handling, a zero flag and an illegal-encoding flag.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage control and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       ALUOp_i;
  logic [6:0]       funct7_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             zero_o;
  logic             illegal_o;

  modport master (
    output valid_i, ALUOp_i, funct7_i, funct3_i, src1_i, src2_i,
    input  ready_o, result_o, valid_o, zero_o, illegal_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct7_i, funct3_i, src1_i, src2_i,
    output ready_o, result_o, valid_o, zero_o, illegal_o
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential RISC-V ALU: single-cycle logic/arith ops, iterative shift-add MUL.
// The bus interface must be instantiated with the same WIDTH as this module.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input logic      clk_i,
  input logic      rst_i,
  alu_seq_if.slave bus
);
  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int SHW   = $clog2(WIDTH);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic { S_IDLE, S_MUL } state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_MUL, OP_ILL
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  op_e              op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]   shamt;

  assign shamt = bus.src2_i[SHW-1:0];

  // Decode ALUOp/funct3/funct7 into one operation code
  always_comb begin
    op = OP_ILL;
    case (bus.ALUOp_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (bus.funct3_i == 3'b000)      op = OP_ADD;
        else if (bus.funct3_i == 3'b101) op = OP_SRA;
      end
      default: begin
        case (bus.funct3_i)
          3'b111: op = OP_AND;
          3'b100: op = OP_XOR;
          3'b001: op = OP_SLL;
          3'b000: begin
            if (bus.funct7_i == 7'b0000000)      op = OP_ADD;
            else if (bus.funct7_i == 7'b0100000) op = OP_SUB;
            else if (bus.funct7_i == 7'b0000001) op = OP_MUL;
          end
          default: op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle execution; illegal encodings (and MUL, handled elsewhere) yield 0
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
      OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
      OP_AND:  alu_res = bus.src1_i & bus.src2_i;
      OP_XOR:  alu_res = bus.src1_i ^ bus.src2_i;
      OP_SLL:  alu_res = bus.src1_i << shamt;
      OP_SRA:  alu_res = WIDTH'($signed(bus.src1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand times the low MUL_BITS of the multiplier
  always_comb begin
    acc_nxt = acc_q + mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
  end

  // Next-state: accept in IDLE, iterate in MUL, publish result on completion
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          if (op == OP_MUL) begin
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            acc_d    = '0;
            cnt_d    = CW'(STEPS - 1);
            state_d  = S_MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OP_ILL);
            valid_d   = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d  = acc_nxt;
          zero_d    = (acc_nxt == '0);
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any multiply in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ready_o   = (state_q == S_IDLE);
  assign bus.result_o  = result_q;
  assign bus.valid_o   = valid_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (MUL_BITS=1 and 4) share operand
// fields; a cycle-level reference model checks both on every falling edge.
module tb_alu_seq;
  logic        clk, rst;
  logic [1:0]  vi;
  logic [1:0]  aluop;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] s1, s2;
  logic [1:0]  rdy, vo, zo, io;
  logic [31:0] res [2];

  int n_vec = 0;
  int n_err = 0;

  alu_seq_if #(.WIDTH(32)) if_a ();
  alu_seq_if #(.WIDTH(32)) if_b ();

  assign if_a.valid_i  = vi[0];
  assign if_a.ALUOp_i  = aluop;
  assign if_a.funct7_i = f7;
  assign if_a.funct3_i = f3;
  assign if_a.src1_i   = s1;
  assign if_a.src2_i   = s2;
  assign if_b.valid_i  = vi[1];
  assign if_b.ALUOp_i  = aluop;
  assign if_b.funct7_i = f7;
  assign if_b.funct3_i = f3;
  assign if_b.src1_i   = s1;
  assign if_b.src2_i   = s2;
  assign rdy    = {if_b.ready_o,   if_a.ready_o};
  assign vo     = {if_b.valid_o,   if_a.valid_o};
  assign zo     = {if_b.zero_o,    if_a.zero_o};
  assign io     = {if_b.illegal_o, if_a.illegal_o};
  assign res[0] = if_a.result_o;
  assign res[1] = if_b.result_o;

  alu_seq #(.WIDTH(32), .MUL_BITS(1)) u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  alu_seq #(.WIDTH(32), .MUL_BITS(4)) u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Architectural meaning of an encoding, straight from the ISA rules
  function automatic void calc(input logic [1:0] op, input logic [6:0] fs, input logic [2:0] ft,
                               input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output logic il, output logic mul);
    r = 32'h0; il = 1'b0; mul = 1'b0;
    if (op == 2'd0)      r = a + b;
    else if (op == 2'd1) r = a - b;
    else if (op == 2'd2) begin
      if (ft == 3'd0)      r = a + b;
      else if (ft == 3'd5) r = $signed(a) >>> (b % 32);
      else                 il = 1'b1;
    end else begin
      if (ft == 3'd7)      r = a & b;
      else if (ft == 3'd4) r = a ^ b;
      else if (ft == 3'd1) r = a << (b % 32);
      else if (ft == 3'd0 && fs == 7'h00) r = a + b;
      else if (ft == 3'd0 && fs == 7'h20) r = a - b;
      else if (ft == 3'd0 && fs == 7'h01) begin r = a * b; mul = 1'b1; end
      else il = 1'b1;
    end
  endfunction

  // Reference model: what each output must be in the current cycle
  typedef struct {
    int          busy;
    logic        v;
    logic [31:0] r;
    logic        z;
    logic        il;
    logic [31:0] pend;
  } mdl_t;
  mdl_t m [2];
  int   steps [2] = '{32, 8};

  always @(negedge clk) begin
    logic [31:0] r;
    logic il, mul;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m[d].busy = 0; m[d].v = 1'b0; m[d].r = 32'h0; m[d].z = 1'b1; m[d].il = 1'b0;
      end else begin
        chk("ready",   d, 32'(rdy[d]), 32'(m[d].busy == 0));
        chk("valid",   d, 32'(vo[d]),  32'(m[d].v));
        chk("result",  d, res[d],      m[d].r);
        chk("zero",    d, 32'(zo[d]),  32'(m[d].z));
        chk("illegal", d, 32'(io[d]),  32'(m[d].il));
        m[d].v = 1'b0;
        if (m[d].busy > 0) begin
          m[d].busy--;
          if (m[d].busy == 0) begin
            m[d].v = 1'b1; m[d].r = m[d].pend; m[d].z = (m[d].pend == 0); m[d].il = 1'b0;
          end
        end else if (vi[d]) begin
          calc(aluop, f7, f3, s1, s2, r, il, mul);
          if (mul) begin
            m[d].busy = steps[d]; m[d].pend = r;
          end else begin
            m[d].v = 1'b1; m[d].r = r; m[d].z = (r == 0); m[d].il = il;
          end
        end
      end
    end
  end

  // Present an op on one DUT and hold valid until it is accepted
  task automatic issue(input int d, input logic [1:0] op, input logic [6:0] fs, input logic [2:0] ft,
                       input logic [31:0] a, input logic [31:0] b, output int waited);
    bit ok = 1'b0;
    aluop = op; f7 = fs; f3 = ft; s1 = a; s2 = b;
    vi[d] = 1'b1;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      waited++;
      if (rdy[d]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", d, 32'd0, 32'd1);
    @(posedge clk);
    #1 vi[d] = 1'b0;
  endtask

  // Wait for the completion pulse and pin it against hand-computed values
  task automatic wait_pulse(input int d, input logic [31:0] er, input logic ez, input logic ei, input int elat);
    int n = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (vo[d]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("pulse_timeout", d, 32'd0, 32'd1);
    else begin
      chk("lit_latency", d, 32'(n),     32'(elat));
      chk("lit_result",  d, res[d],     er);
      chk("lit_zero",    d, 32'(zo[d]), 32'(ez));
      chk("lit_illegal", d, 32'(io[d]), 32'(ei));
    end
  endtask

  task automatic lit_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",   d, 32'(rdy[d]), 32'd1);
      chk("rst_valid",   d, 32'(vo[d]),  32'd0);
      chk("rst_result",  d, res[d],      32'h0);
      chk("rst_zero",    d, 32'(zo[d]),  32'd1);
      chk("rst_illegal", d, 32'(io[d]),  32'd0);
    end
  endtask

  initial begin
    int w;
    rst = 1'b0; vi = 2'b00; aluop = 2'd0; f7 = 7'd0; f3 = 3'd0; s1 = 32'd0; s2 = 32'd0;
    #2 rst = 1'b1;
    #1 lit_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // SUB to zero, then ADD wrap
    issue(0, 2'b11, 7'h20, 3'b000, 32'd5, 32'd5, w);          wait_pulse(0, 32'h0, 1'b1, 1'b0, 1);
    issue(0, 2'b00, 7'h00, 3'b000, 32'hFFFF_FFFF, 32'd1, w);  wait_pulse(0, 32'h0, 1'b1, 1'b0, 1);
    issue(1, 2'b01, 7'h00, 3'b000, 32'd9, 32'd4, w);          wait_pulse(1, 32'd5, 1'b0, 1'b0, 1);

    // MUL on both radices
    issue(0, 2'b11, 7'h01, 3'b000, 32'hFFFF_FFFF, 32'd3, w);  wait_pulse(0, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
    issue(1, 2'b11, 7'h01, 3'b000, 32'hFFFF_FFFF, 32'd3, w);  wait_pulse(1, 32'hFFFF_FFFD, 1'b0, 1'b0, 9);
    issue(1, 2'b11, 7'h01, 3'b000, 32'h0001_0000, 32'h0001_0000, w); wait_pulse(1, 32'h0, 1'b1, 1'b0, 9);

    // AND held during busy window is taken only once ready returns
    issue(0, 2'b11, 7'h01, 3'b000, 32'h1234, 32'h10, w);
    issue(0, 2'b11, 7'h00, 3'b111, 32'hF0F0, 32'hFF00, w);
    chk("lit_busy_wait", 0, 32'(w), 32'd33);
    wait_pulse(0, 32'h0000_F000, 1'b0, 1'b0, 1);
    issue(1, 2'b11, 7'h01, 3'b000, 32'h1234, 32'h10, w);
    issue(1, 2'b11, 7'h00, 3'b111, 32'hF0F0, 32'hFF00, w);
    chk("lit_busy_wait", 1, 32'(w), 32'd9);
    wait_pulse(1, 32'h0000_F000, 1'b0, 1'b0, 1);

    // Shifts
    issue(0, 2'b10, 7'h00, 3'b101, 32'h8000_0000, 32'd36, w); wait_pulse(0, 32'hF800_0000, 1'b0, 1'b0, 1);
    issue(1, 2'b10, 7'h7F, 3'b101, 32'h8000_0000, 32'd36, w); wait_pulse(1, 32'hF800_0000, 1'b0, 1'b0, 1);
    issue(0, 2'b11, 7'h00, 3'b001, 32'd1, 32'd31, w);         wait_pulse(0, 32'h8000_0000, 1'b0, 1'b0, 1);

    // Illegal encodings, then recovery
    issue(0, 2'b11, 7'h00, 3'b010, 32'd7, 32'd8, w);          wait_pulse(0, 32'h0, 1'b1, 1'b1, 1);
    issue(0, 2'b00, 7'h00, 3'b000, 32'd7, 32'd8, w);          wait_pulse(0, 32'd15, 1'b0, 1'b0, 1);
    issue(1, 2'b11, 7'h02, 3'b000, 32'd7, 32'd8, w);          wait_pulse(1, 32'h0, 1'b1, 1'b1, 1);

    // Back-to-back single-cycle ops on both DUTs
    @(posedge clk);
    #1 vi = 2'b11; aluop = 2'b11; f7 = 7'h00; f3 = 3'b100; s1 = 32'hAAAA_5555; s2 = 32'hFFFF_0000;
    @(posedge clk);
    #1 aluop = 2'b01; s1 = 32'd3; s2 = 32'd5;
    @(posedge clk);
    #1 aluop = 2'b10; f3 = 3'b000; s1 = 32'd100; s2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 vi = 2'b00;
    @(negedge clk);
    chk("lit_b2b_last", 0, res[0], 32'd99);
    chk("lit_b2b_last", 1, res[1], 32'd99);

    // Reset in the middle of a multiply
    issue(0, 2'b11, 7'h01, 3'b000, 32'd6, 32'd7, w);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 lit_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 issue(0, 2'b00, 7'h00, 3'b000, 32'd2, 32'd3, w);       wait_pulse(0, 32'd5, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
